switch_pio_in: RTL and testbench

//  Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO.
//  - Samples WIDTH external inputs (slide switches / keys) through a synchronizer and a per-bit debouncer.
//  - Records edges in a sticky edge-capture register and raises a maskable level interrupt to the processor.
//  - Zero-wait-state reads. Sits on the same system interconnect as the LED PIO.

---
 rtl/switch_pio_in.sv | 113 +++++++++++
 tb/tb_switch_pio_in.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/switch_pio_in.sv
// Avalon-MM input PIO: synchronized, debounced switch inputs with
// sticky edge capture and a maskable level interrupt.
module switch_pio_in #(
   parameter int WIDTH           = 18,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] clr;
   logic             wr_en;
   logic             unused_wd;

   assign sync_q    = sync_r[SYNC_STAGES-1];
   assign wr_en     = chipselect & ~write_n;
   assign unused_wd = &{1'b0, writedata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++)
            sync_r[s] <= '0;
      end else begin
         sync_r[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_r[s] <= sync_r[s-1];
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) stable <= '0;
         else          stable <= sync_q;
      end
   end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt [WIDTH];

      // counter runs only while the bit disagrees; it restarts on any match
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++)
               cnt[i] <= '0;
         end else begin
            for (int i = 0; i < WIDTH; i++) begin
               if (sync_q[i] == stable[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == LAST) begin
                  stable[i] <= sync_q[i];
                  cnt[i]    <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_hit = stable & ~stable_d;
         1:       edge_hit = ~stable & stable_d;
         default: edge_hit = stable ^ stable_d;
      endcase
   end

   assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // a fresh edge overrides a same-cycle software clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d     <= '0;
         irq_mask     <= '0;
         edge_capture <= '0;
      end else begin
         stable_d     <= stable;
         edge_capture <= (edge_capture & ~clr) | edge_hit;
         if (wr_en && address == 2'd2)
            irq_mask <= writedata[WIDTH-1:0];
      end
   end

   assign irq = |(edge_capture & irq_mask);

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = stable;
         2'd2:    readdata[WIDTH-1:0] = irq_mask;
         2'd3:    readdata[WIDTH-1:0] = edge_capture;
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_switch_pio_in.sv
// Directed bench for switch_pio_in: default build plus an
// any-edge, no-debounce build.
module tb_switch_pio_in;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [17:0] in_port = '0;
   logic        irq;

   logic [1:0]  address_b = '0;
   logic        chipselect_b = 1'b0;
   logic        write_n_b = 1'b1;
   logic [31:0] writedata_b = '0;
   logic [31:0] readdata_b;
   logic [17:0] in_port_b = 18'h00008;
   logic        irq_b;

   int passed = 0;
   int total  = 0;
   logic seen;

   always #5 clk = ~clk;

   switch_pio_in dut (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .irq(irq)
   );

   switch_pio_in #(
      .WIDTH(18), .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .address(address_b),
      .chipselect(chipselect_b), .write_n(write_n_b),
      .writedata(writedata_b), .readdata(readdata_b),
      .in_port(in_port_b), .irq(irq_b)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input string tag, input logic [1:0] a,
                     input logic [31:0] exp);
      address = a;
      #1;
      check(tag, readdata, exp);
   endtask

   task automatic rd_b(input string tag, input logic [1:0] a,
                       input logic [31:0] exp);
      address_b = a;
      #1;
      check(tag, readdata_b, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
      address_b    = a;
      writedata_b  = d;
      chipselect_b = 1'b1;
      write_n_b    = 1'b0;
      tick();
      chipselect_b = 1'b0;
      write_n_b    = 1'b1;
   endtask

   initial begin
      in_port = 18'h3FFFF;
      tick(3);
      rd("rst_a0", 2'd0, 32'h0);
      rd("rst_a1", 2'd1, 32'h0);
      rd("rst_a2", 2'd2, 32'h0);
      rd("rst_a3", 2'd3, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);

      reset_n = 1'b1;
      tick(17);
      rd("lat17", 2'd0, 32'h0);
      tick();
      rd("lat18", 2'd0, 32'h0003FFFF);
      tick();
      rd("cap19", 2'd3, 32'h0003FFFF);
      check("irq_nomask", {31'h0, irq}, 32'h0);
      wr(2'd3, 32'hFFFFFFFF);
      rd("clr_all", 2'd3, 32'h0);

      in_port = '0;
      tick(20);
      rd("low_a0", 2'd0, 32'h0);
      rd("fall_nocap", 2'd3, 32'h0);

      wr(2'd2, 32'h00000001);
      rd("mask", 2'd2, 32'h00000001);

      seen = 1'b0;
      address = 2'd0;
      in_port = 18'h00001;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | readdata[0];
      end
      in_port = '0;
      for (int i = 0; i < 30; i++) begin
         tick();
         seen = seen | readdata[0];
      end
      check("glitch", {31'h0, seen}, 32'h0);
      rd("glitch_cap", 2'd3, 32'h0);

      in_port = 18'h00001;
      tick(17);
      rd("hold17", 2'd0, 32'h0);
      tick();
      rd("hold18", 2'd0, 32'h00000001);
      check("irq18", {31'h0, irq}, 32'h0);
      tick();
      rd("cap_b0", 2'd3, 32'h00000001);
      check("irq19", {31'h0, irq}, 32'h1);

      in_port = 18'h00021;
      tick(19);
      rd("cap_b5", 2'd3, 32'h00000021);
      rd("data21", 2'd0, 32'h00000021);
      check("irq_b5", {31'h0, irq}, 32'h1);

      wr(2'd3, 32'h00000001);
      rd("w1c", 2'd3, 32'h00000020);
      check("irq_w1c", {31'h0, irq}, 32'h0);

      in_port = 18'h00020;
      tick(20);
      in_port = 18'h00021;
      tick(19);
      rd("recap", 2'd3, 32'h00000021);
      in_port = 18'h00020;
      tick(20);
      rd("sticky", 2'd3, 32'h00000021);
      in_port = 18'h00021;
      tick(18);
      wr(2'd3, 32'h00000001);
      rd("collide", 2'd3, 32'h00000021);
      check("irq_coll", {31'h0, irq}, 32'h1);
      rd("resv", 2'd1, 32'h0);

      rd_b("b_rise", 2'd3, 32'h00000008);
      wr_b(2'd3, 32'hFFFFFFFF);
      rd_b("b_clr", 2'd3, 32'h0);
      in_port_b = '0;
      tick(3);
      rd_b("b_fall3", 2'd3, 32'h0);
      rd_b("b_data3", 2'd0, 32'h0);
      tick();
      rd_b("b_fall4", 2'd3, 32'h00000008);
      wr_b(2'd2, 32'hFFFFFFFF);
      rd_b("b_mask", 2'd2, 32'h0003FFFF);
      check("b_irq", {31'h0, irq_b}, 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
